// File: rtl/axis_flit_packer_if.sv
// AXI-Stream bundle with destination sideband, shared by the packer's input and output sides.
// The master drives data/valid/last/destination; the slave returns ready.
interface axis_flit_packer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int X_W        = 2,
    parameter int Y_W        = 2
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [X_W-1:0]        dest_x;
    logic [Y_W-1:0]        dest_y;

    modport master (output tdata, tvalid, tlast, dest_x, dest_y, input tready);
    modport slave  (input tdata, tvalid, tlast, dest_x, dest_y, output tready);
endinterface

// File: rtl/axis_flit_packer.sv
// Packs an AXI-Stream payload into router flits: header (dst/src coords) + up to MAX_PACKAGES bodies.
// Optional macro PACKER_DEST_CHECK_EN: out-of-mesh destinations pulse dest_err and the payload is dropped.
module axis_flit_packer #(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_ROUTERS_X = 4,
    parameter int MAX_ROUTERS_Y = 4,
    parameter int ROUTER_X      = 0,
    parameter int ROUTER_Y      = 0,
    parameter int MAX_PACKAGES  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    axis_flit_packer_if.slave  in_if,
    axis_flit_packer_if.master out_if,
    output logic               dest_err
);
    localparam int X_W   = $clog2(MAX_ROUTERS_X);
    localparam int Y_W   = $clog2(MAX_ROUTERS_Y);
    localparam int CNT_W = $clog2(MAX_PACKAGES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_PACKAGES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BODY  = 2'd1,
`ifdef PACKER_DEST_CHECK_EN
        SPLIT = 2'd2,
        DROP  = 2'd3
`else
        SPLIT = 2'd2
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [X_W-1:0]        dst_x_q, dst_x_d;
    logic [Y_W-1:0]        dst_y_q, dst_y_d;
    logic                  in_ready;
    logic                  free;

    function automatic logic [DATA_WIDTH-1:0] pack_header(input logic [X_W-1:0] x,
                                                          input logic [Y_W-1:0] y);
        logic [DATA_WIDTH-1:0] h;
        h                      = '0;
        h[0 +: X_W]            = x;
        h[X_W +: Y_W]          = y;
        h[X_W+Y_W +: X_W]      = X_W'(ROUTER_X);
        h[2*X_W+Y_W +: Y_W]    = Y_W'(ROUTER_Y);
        return h;
    endfunction

    // The output register may only change when empty or being drained this cycle.
    assign free = !tvalid_q || out_if.tready;

`ifdef PACKER_DEST_CHECK_EN
    localparam logic [X_W:0] X_LIM = (X_W+1)'(MAX_ROUTERS_X);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(MAX_ROUTERS_Y);
    logic dest_bad;
    logic err_q, err_d;
    assign dest_bad = ({1'b0, in_if.dest_x} >= X_LIM) || ({1'b0, in_if.dest_y} >= Y_LIM);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tvalid_d = free ? 1'b0 : tvalid_q;
        dst_x_d  = dst_x_q;
        dst_y_d  = dst_y_q;
        in_ready = 1'b0;
`ifdef PACKER_DEST_CHECK_EN
        err_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef PACKER_DEST_CHECK_EN
                if (in_if.tvalid && dest_bad) begin
                    err_d   = 1'b1;
                    state_d = DROP;
                end else
`endif
                if (in_if.tvalid && free) begin
                    dst_x_d  = in_if.dest_x;
                    dst_y_d  = in_if.dest_y;
                    tdata_d  = pack_header(in_if.dest_x, in_if.dest_y);
                    tlast_d  = 1'b0;
                    tvalid_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = BODY;
                end
            end
            BODY: begin
                in_ready = free;
                if (in_if.tvalid && free) begin
                    tdata_d  = in_if.tdata;
                    tvalid_d = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (in_if.tlast) begin
                        tlast_d = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (cnt_q == LAST_CNT) begin
                        tlast_d = 1'b1;
                        cnt_d   = '0;
                        state_d = SPLIT;
                    end else begin
                        tlast_d = 1'b0;
                    end
                end
            end
            SPLIT: begin
                // Continuation packets reuse the destination latched at the start of the payload.
                if (free) begin
                    tdata_d  = pack_header(dst_x_q, dst_y_q);
                    tlast_d  = 1'b0;
                    tvalid_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = BODY;
                end
            end
`ifdef PACKER_DEST_CHECK_EN
            DROP: begin
                in_ready = 1'b1;
                if (in_if.tvalid && in_if.tlast) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    always_ff @(posedge clk) begin
        dst_x_q <= dst_x_d;
        dst_y_q <= dst_y_d;
    end

`ifdef PACKER_DEST_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign dest_err = err_q;
`else
    assign dest_err = 1'b0;
`endif

    assign in_if.tready  = in_ready;
    assign out_if.tdata  = tdata_q;
    assign out_if.tvalid = tvalid_q;
    assign out_if.tlast  = tlast_q;
    assign out_if.dest_x = dst_x_q;
    assign out_if.dest_y = dst_y_q;
endmodule
